// File: rtl/ysyx_22041207_lsu_axi_if.sv
// Pipeline request/response port and AXI-bridge channels of the memory-stage LSU.
// Handshake rule for every valid/ready pair: the transfer happens on the rising edge where both are 1; a raised valid stays high with a stable payload until that edge.
interface ysyx_22041207_lsu_axi_if #(
  parameter int DW = 64,
  parameter int AW = 64
);
  localparam int NB = DW / 8;

  logic          req_valid;
  logic          req_ready;
  logic          req_wen;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [1:0]    req_size;
  logic          req_sext;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic          me_wait_for_axi;

  logic          w_valid_i;
  logic          w_ready_o;
  logic [AW-1:0] w_addr_i;
  logic [DW-1:0] w_data_i;
  logic [NB-1:0] w_mask_i;
  logic          w_valid_o;
  logic          w_ready_i;
  logic          w_err_o;

  logic          rx_r_valid_i;
  logic          rx_r_ready_o;
  logic [AW-1:0] rx_r_addr_i;
  logic [2:0]    rx_r_size_i;
  logic          rx_data_valid;
  logic          rx_data_ready;
  logic [DW-1:0] rx_data_read_o;
  logic          rx_err_o;

  modport master (
    input  req_valid, req_wen, req_addr, req_wdata, req_size, req_sext,
    output req_ready, resp_valid, resp_rdata, resp_err, me_wait_for_axi,
    output w_valid_i, w_addr_i, w_data_i, w_mask_i, w_ready_i,
    input  w_ready_o, w_valid_o, w_err_o,
    output rx_r_valid_i, rx_r_addr_i, rx_r_size_i, rx_data_ready,
    input  rx_r_ready_o, rx_data_valid, rx_data_read_o, rx_err_o
  );

  modport slave (
    output req_valid, req_wen, req_addr, req_wdata, req_size, req_sext,
    input  req_ready, resp_valid, resp_rdata, resp_err, me_wait_for_axi,
    input  w_valid_i, w_addr_i, w_data_i, w_mask_i, w_ready_i,
    output w_ready_o, w_valid_o, w_err_o,
    input  rx_r_valid_i, rx_r_addr_i, rx_r_size_i, rx_data_ready,
    output rx_r_ready_o, rx_data_valid, rx_data_read_o, rx_err_o
  );
endinterface

// File: rtl/ysyx_22041207_lsu_axi.sv
// Memory-stage load/store unit: one request at a time, issued on split read/write
// valid/ready channels, with byte-lane alignment and load extension.
module ysyx_22041207_lsu_axi #(
  parameter int DW = 64,
  parameter int AW = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ysyx_22041207_lsu_axi_if.master bus,
  output logic [2:0]             dbg_state_o
);
  localparam int NB = DW / 8;
  localparam int OW = $clog2(NB);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_B, S_RESP} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    size_q, size_d;
  logic          sext_q, sext_d;
  logic [OW-1:0] off_q, off_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [NB-1:0] mask_q, mask_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [OW-1:0] off_in;
  logic          misalign;
  logic          oversize;
  logic [NB-1:0] lane_mask;
  logic [DW-1:0] shifted;
  logic [DW-1:0] load_val;
  logic          sign_bit;

  assign off_in = bus.req_addr[OW-1:0];

  always_comb begin
    misalign = 1'b0;
    for (int i = 0; i < OW; i++) begin
      if (i < int'(bus.req_size) && bus.req_addr[i]) misalign = 1'b1;
    end
    oversize = int'(bus.req_size) > OW;
    lane_mask = '0;
    for (int i = 0; i < NB; i++) begin
      lane_mask[i] = (i < (1 << bus.req_size));
    end
  end

  // Bring the addressed bytes down to bit 0, then fill above the access width.
  always_comb begin
    shifted  = bus.rx_data_read_o >> {off_q, 3'b000};
    sign_bit = shifted[DW-1];
    case (size_q)
      2'd0:    sign_bit = shifted[7];
      2'd1:    sign_bit = shifted[15];
      2'd2:    sign_bit = shifted[31];
      default: sign_bit = shifted[DW-1];
    endcase
    load_val = shifted;
    for (int i = 0; i < DW; i++) begin
      if (i >= (8 << size_q)) load_val[i] = sign_bit & sext_q;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    sext_d  = sext_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          addr_d  = {bus.req_addr[AW-1:OW], {OW{1'b0}}};
          size_d  = bus.req_size;
          sext_d  = bus.req_sext;
          off_d   = off_in;
          wdata_d = bus.req_wdata << {off_in, 3'b000};
          mask_d  = lane_mask << off_in;
          if (misalign || oversize) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = S_RESP;
          end else begin
            state_d = bus.req_wen ? S_AW : S_AR;
          end
        end
      end
      S_AW: if (bus.w_ready_o) state_d = S_B;
      S_B: begin
        if (bus.w_valid_o) begin
          err_d   = bus.w_err_o;
          rdata_d = '0;
          state_d = S_RESP;
        end
      end
      S_AR: if (bus.rx_r_ready_o) state_d = S_R;
      S_R: begin
        if (bus.rx_data_valid) begin
          err_d   = bus.rx_err_o;
          rdata_d = bus.rx_err_o ? '0 : load_val;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      off_q   <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready       = (state_q == S_IDLE);
  assign bus.me_wait_for_axi = (state_q != S_IDLE);
  assign bus.resp_valid      = (state_q == S_RESP);
  assign bus.resp_rdata      = rdata_q;
  assign bus.resp_err        = err_q;

  assign bus.w_valid_i = (state_q == S_AW);
  assign bus.w_addr_i  = addr_q;
  assign bus.w_data_i  = wdata_q;
  assign bus.w_mask_i  = mask_q;
  assign bus.w_ready_i = (state_q == S_B);

  assign bus.rx_r_valid_i  = (state_q == S_AR);
  assign bus.rx_r_addr_i   = addr_q;
  assign bus.rx_r_size_i   = {1'b0, size_q};
  assign bus.rx_data_ready = (state_q == S_R);

  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_ysyx_22041207_lsu_axi.sv
// Randomised bench for the LSU: a 64-bit instance driven as both pipeline and bus
// slave with variable stalls, plus a 32-bit instance for oversize/latency cases.
module tb_ysyx_22041207_lsu_axi;
  logic clk;
  logic rst_n;
  logic [2:0] dbg64, dbg32;
  int total = 0;
  int bad = 0;
  logic [63:0] exp_q[$];

  ysyx_22041207_lsu_axi_if #(.DW(64), .AW(64)) bif ();
  ysyx_22041207_lsu_axi_if #(.DW(32), .AW(64)) bif32 ();

  ysyx_22041207_lsu_axi #(.DW(64), .AW(64)) dut (.clk(clk), .rst_n(rst_n), .bus(bif), .dbg_state_o(dbg64));
  ysyx_22041207_lsu_axi #(.DW(32), .AW(64)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bif32), .dbg_state_o(dbg32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (byte-level arithmetic) ----------------
  function automatic logic m_err(input int nb, input logic [63:0] addr, input logic [1:0] size);
    int n, off;
    n = 1 << size;
    off = int'(addr[2:0]) % nb;
    return (n > nb) || ((off % n) != 0);
  endfunction

  function automatic logic [63:0] m_load(input int nb, input logic [63:0] addr, input logic [1:0] size,
                                         input logic sext, input logic [63:0] beat);
    int n, off;
    logic [63:0] v;
    n = 1 << size;
    off = int'(addr[2:0]) % nb;
    v = '0;
    for (int k = 0; k < n; k++) v = v | (64'(beat[8*(off+k) +: 8]) << (8*k));
    if (sext && v[8*n-1]) for (int b = 8*n; b < 64; b++) v[b] = 1'b1;
    if (nb == 4) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  function automatic logic [7:0] m_mask(input logic [63:0] addr, input logic [1:0] size);
    int n, off;
    logic [7:0] mk;
    n = 1 << size;
    off = int'(addr[2:0]);
    mk = '0;
    for (int k = 0; k < n; k++) mk[off+k] = 1'b1;
    return mk;
  endfunction

  // ---------------- one full transaction on the 64-bit instance ----------------
  // Caller is at a negedge with the unit idle; returns at the negedge after RESP.
  task automatic run_txn(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [1:0] size, input logic sext, input logic [63:0] beat,
                         input logic berr, input int adly, input int rdly, output logic [63:0] got);
    logic e, done, eerr;
    logic [63:0] er, ea, ed, popped;
    logic [7:0] em;
    int cyc, acnt, rcnt, exp_lat, vcyc;
    e = m_err(8, addr, size);
    ea = {addr[63:3], 3'b000};
    em = e ? 8'h00 : m_mask(addr, size);
    ed = wdata << (8 * int'(addr[2:0]));
    er = (e || wen || berr) ? 64'h0 : m_load(8, addr, size, sext, beat);
    eerr = e | berr;
    exp_q.push_back(er);
    exp_lat = e ? 1 : 3 + adly + rdly;
    got = '0;
    total++;
    if (bif.req_ready !== 1'b1) begin bad++; $display("FAIL req_ready_idle got=%0b exp=1", bif.req_ready); end
    bif.req_valid = 1'b1; bif.req_wen = wen; bif.req_addr = addr;
    bif.req_wdata = wdata; bif.req_size = size; bif.req_sext = sext;
    @(negedge clk);
    bif.req_valid = 1'b0;
    bif.req_wdata = {$urandom, $urandom};
    cyc = 1; acnt = 0; rcnt = 0; vcyc = 0; done = 1'b0;
    while (!done && cyc <= 40) begin
      bif.w_ready_o = 1'b0; bif.w_valid_o = 1'b0; bif.w_err_o = 1'b0;
      bif.rx_r_ready_o = 1'b0; bif.rx_data_valid = 1'b0; bif.rx_err_o = 1'b0;
      bif.rx_data_read_o = {$urandom, $urandom};
      total++;
      if (bif.me_wait_for_axi !== 1'b1) begin bad++; $display("FAIL stall cyc=%0d got=%0b exp=1", cyc, bif.me_wait_for_axi); end
      if (bif.resp_valid === 1'b1) begin
        done = 1'b1;
        popped = exp_q.pop_front();
        got = bif.resp_rdata;
        total++;
        if (cyc != exp_lat) begin bad++; $display("FAIL resp_latency got=%0d exp=%0d", cyc, exp_lat); end
        total++;
        if (bif.resp_err !== eerr) begin bad++; $display("FAIL resp_err got=%0b exp=%0b", bif.resp_err, eerr); end
        total++;
        if (bif.resp_rdata !== popped) begin bad++; $display("FAIL resp_rdata got=%h exp=%h", bif.resp_rdata, popped); end
      end else begin
        total++;
        if (bif.req_ready !== 1'b0) begin bad++; $display("FAIL req_ready_busy got=%0b exp=0", bif.req_ready); end
        if (bif.w_valid_i === 1'b1) begin
          vcyc++;
          total++;
          if (e || !wen) begin bad++; $display("FAIL unexpected_w_valid got=1 exp=0"); end
          total++;
          if (bif.w_addr_i !== ea || bif.w_mask_i !== em || bif.w_data_i !== ed) begin
            bad++;
            $display("FAIL w_payload got=%h/%h/%h exp=%h/%h/%h", bif.w_addr_i, bif.w_mask_i, bif.w_data_i, ea, em, ed);
          end
          if (acnt == adly) bif.w_ready_o = 1'b1; else acnt++;
        end
        if (bif.w_ready_i === 1'b1) begin
          if (rcnt == rdly) begin bif.w_valid_o = 1'b1; bif.w_err_o = berr; end else rcnt++;
        end
        if (bif.rx_r_valid_i === 1'b1) begin
          vcyc++;
          total++;
          if (e || wen) begin bad++; $display("FAIL unexpected_r_valid got=1 exp=0"); end
          total++;
          if (bif.rx_r_addr_i !== ea || bif.rx_r_size_i !== {1'b0, size}) begin
            bad++;
            $display("FAIL r_payload got=%h/%0d exp=%h/%0d", bif.rx_r_addr_i, bif.rx_r_size_i, ea, size);
          end
          if (acnt == adly) bif.rx_r_ready_o = 1'b1; else acnt++;
        end
        if (bif.rx_data_ready === 1'b1) begin
          if (rcnt == rdly) begin bif.rx_data_valid = 1'b1; bif.rx_err_o = berr; bif.rx_data_read_o = beat; end
          else rcnt++;
        end
      end
      @(negedge clk);
      if (!done) cyc++;
    end
    bif.w_ready_o = 1'b0; bif.w_valid_o = 1'b0; bif.w_err_o = 1'b0;
    bif.rx_r_ready_o = 1'b0; bif.rx_data_valid = 1'b0; bif.rx_err_o = 1'b0;
    if (!done) begin
      bad++; total++;
      void'(exp_q.pop_front());
      $display("FAIL resp_timeout got=none exp=resp_valid");
    end else begin
      total++;
      if (vcyc != (e ? 0 : adly + 1)) begin bad++; $display("FAIL addr_valid_cycles got=%0d exp=%0d", vcyc, e ? 0 : adly + 1); end
      total++;
      if ({bif.resp_valid, bif.me_wait_for_axi, bif.req_ready} !== 3'b001) begin
        bad++; $display("FAIL post_resp got=%b exp=001", {bif.resp_valid, bif.me_wait_for_axi, bif.req_ready});
      end
      total++;
      if (bif.resp_rdata !== er || bif.resp_err !== eerr) begin
        bad++; $display("FAIL resp_hold got=%h/%0b exp=%h/%0b", bif.resp_rdata, bif.resp_err, er, eerr);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({bif.resp_valid, bif.me_wait_for_axi, bif.w_valid_i, bif.w_ready_i, bif.rx_r_valid_i, bif.rx_data_ready, bif.resp_err} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=0000000", {bif.resp_valid, bif.me_wait_for_axi, bif.w_valid_i, bif.w_ready_i,
               bif.rx_r_valid_i, bif.rx_data_ready, bif.resp_err});
    end
    total++;
    if ((|{bif.w_addr_i, bif.w_data_i, bif.w_mask_i, bif.rx_r_addr_i, bif.rx_r_size_i, bif.resp_rdata}) !== 1'b0) begin
      bad++; $display("FAIL reset_payload got=nonzero exp=0");
    end
    total++;
    if (bif.req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%0b exp=1", bif.req_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_store_sb();
    logic [63:0] got;
    run_txn(1'b1, 64'h1003, 64'hAB, 2'd0, 1'b0, 64'h0, 1'b0, 0, 0, got);
  endtask

  task automatic test_load_lh();
    logic [63:0] got;
    run_txn(1'b0, 64'h2006, 64'h0, 2'd1, 1'b1, 64'h8001_0000_0000_0000, 1'b0, 0, 0, got);
    total++;
    if (got !== 64'hFFFF_FFFF_FFFF_8001) begin bad++; $display("FAIL lh_sext got=%h exp=ffffffffffff8001", got); end
    run_txn(1'b0, 64'h2006, 64'h0, 2'd1, 1'b0, 64'h8001_0000_0000_0000, 1'b0, 0, 0, got);
    total++;
    if (got !== 64'h0000_0000_0000_8001) begin bad++; $display("FAIL lhu got=%h exp=0000000000008001", got); end
  endtask

  task automatic test_misaligned();
    logic [63:0] got;
    run_txn(1'b0, 64'h3002, 64'h0, 2'd2, 1'b0, {$urandom, $urandom}, 1'b0, 0, 0, got);
    run_txn(1'b1, 64'h3005, 64'h1234, 2'd1, 1'b0, 64'h0, 1'b0, 0, 0, got);
  endtask

  task automatic test_stall_and_bus_err();
    logic [63:0] got;
    run_txn(1'b1, 64'h4010, {$urandom, $urandom}, 2'd3, 1'b0, 64'h0, 1'b1, 5, 2, got);
    run_txn(1'b0, 64'h5004, 64'h0, 2'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1, 3, got);
  endtask

  // Requests issued in the very cycle after RESP to exercise back-to-back acceptance.
  task automatic test_back_to_back();
    logic [63:0] got, addr;
    logic [1:0] size;
    for (int t = 0; t < 80; t++) begin
      size = 2'($urandom_range(0, 3));
      addr = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) addr = addr & ~((64'd1 << size) - 64'd1);
      run_txn(1'($urandom_range(0, 1)), addr, {$urandom, $urandom}, size, 1'($urandom_range(0, 1)),
              {$urandom, $urandom}, ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), got);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] got;
    logic seen;
    bif.req_valid = 1'b1; bif.req_wen = 1'b0; bif.req_addr = 64'h40; bif.req_size = 2'd2; bif.req_sext = 1'b0;
    @(negedge clk);
    bif.req_valid = 1'b0;
    bif.rx_r_ready_o = 1'b1;
    @(negedge clk);
    bif.rx_r_ready_o = 1'b0;
    total++;
    if (bif.rx_data_ready !== 1'b1) begin bad++; $display("FAIL mid_in_r got=%0b exp=1", bif.rx_data_ready); end
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({bif.resp_valid, bif.me_wait_for_axi, bif.w_valid_i, bif.w_ready_i, bif.rx_r_valid_i, bif.rx_data_ready, bif.resp_err} !== 7'b0) begin
      bad++; $display("FAIL mid_reset_ctrl got=nonzero exp=0");
    end
    total++;
    if ((|{bif.w_addr_i, bif.rx_r_addr_i, bif.rx_r_size_i, bif.resp_rdata, bif.w_mask_i}) !== 1'b0) begin
      bad++; $display("FAIL mid_reset_payload got=nonzero exp=0");
    end
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      if (bif.resp_valid !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    total++;
    if (seen) begin bad++; $display("FAIL mid_reset_resp got=1 exp=0"); end
    run_txn(1'b0, 64'h48, 64'h0, 2'd2, 1'b1, 64'h8765_4321_FEDC_BA98, 1'b0, 0, 0, got);
  endtask

  // 32-bit instance with a bus that is always ready and always returns data.
  task automatic test_dw32();
    logic [63:0] addr, er;
    logic [31:0] beat;
    logic [1:0] size;
    logic sext, e, done, saw_ar;
    int cyc, exp_lat;
    bif32.rx_r_ready_o = 1'b1; bif32.rx_data_valid = 1'b1;
    bif32.w_ready_o = 1'b1; bif32.w_valid_o = 1'b1;
    for (int t = 0; t < 14; t++) begin
      if (t == 0) begin addr = 64'h100; size = 2'd3; sext = 1'b0; beat = $urandom; end
      else if (t == 1) begin addr = 64'h204; size = 2'd2; sext = 1'b0; beat = 32'hDEAD_BEEF; end
      else begin
        size = 2'($urandom_range(0, 3));
        addr = {32'h0, $urandom};
        if ($urandom_range(0, 3) != 0) addr = addr & ~((64'd1 << size) - 64'd1);
        sext = 1'($urandom_range(0, 1));
        beat = $urandom;
      end
      e = m_err(4, addr, size);
      er = e ? 64'h0 : m_load(4, addr, size, sext, {32'h0, beat});
      exp_lat = e ? 1 : 3;
      bif32.rx_data_read_o = beat;
      bif32.req_valid = 1'b1; bif32.req_wen = 1'b0; bif32.req_addr = addr;
      bif32.req_size = size; bif32.req_sext = sext;
      @(negedge clk);
      bif32.req_valid = 1'b0;
      cyc = 1; done = 1'b0; saw_ar = 1'b0;
      while (!done && cyc <= 20) begin
        if (bif32.rx_r_valid_i === 1'b1) saw_ar = 1'b1;
        if (bif32.resp_valid === 1'b1) begin
          done = 1'b1;
          total++;
          if (cyc != exp_lat) begin bad++; $display("FAIL dw32_latency t=%0d got=%0d exp=%0d", t, cyc, exp_lat); end
          total++;
          if (bif32.resp_err !== e) begin bad++; $display("FAIL dw32_err t=%0d got=%0b exp=%0b", t, bif32.resp_err, e); end
          total++;
          if (bif32.resp_rdata !== er[31:0]) begin bad++; $display("FAIL dw32_rdata t=%0d got=%h exp=%h", t, bif32.resp_rdata, er[31:0]); end
        end
        @(negedge clk);
        if (!done) cyc++;
      end
      total++;
      if (!done) begin bad++; $display("FAIL dw32_timeout t=%0d got=none exp=resp_valid", t); end
      total++;
      if (saw_ar !== !e) begin bad++; $display("FAIL dw32_bus_activity t=%0d got=%0b exp=%0b", t, saw_ar, !e); end
    end
    bif32.rx_r_ready_o = 1'b0; bif32.rx_data_valid = 1'b0;
    bif32.w_ready_o = 1'b0; bif32.w_valid_o = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bif.req_valid = 1'b0; bif.req_wen = 1'b0; bif.req_addr = '0; bif.req_wdata = '0;
    bif.req_size = '0; bif.req_sext = 1'b0;
    bif.w_ready_o = 1'b0; bif.w_valid_o = 1'b0; bif.w_err_o = 1'b0;
    bif.rx_r_ready_o = 1'b0; bif.rx_data_valid = 1'b0; bif.rx_data_read_o = '0; bif.rx_err_o = 1'b0;
    bif32.req_valid = 1'b0; bif32.req_wen = 1'b0; bif32.req_addr = '0; bif32.req_wdata = '0;
    bif32.req_size = '0; bif32.req_sext = 1'b0;
    bif32.w_ready_o = 1'b0; bif32.w_valid_o = 1'b0; bif32.w_err_o = 1'b0;
    bif32.rx_r_ready_o = 1'b0; bif32.rx_data_valid = 1'b0; bif32.rx_data_read_o = '0; bif32.rx_err_o = 1'b0;
    test_reset();
    test_store_sb();
    test_load_lh();
    test_misaligned();
    test_stall_and_bus_err();
    test_back_to_back();
    test_reset_mid();
    test_dw32();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ysyx_22041207_lsu_axi.md
# ysyx_22041207_lsu_axi

Parametrised load/store unit for the memory stage of the ysyx_22041207 core. It accepts one load or store request at a time from the pipeline and issues it on separate read and write valid/ready channel pairs to the AXI bridge. For loads it aligns, truncates and sign- or zero-extends the returned beat; for stores it builds the byte-lane data and strobes for every byte offset. Misaligned and oversize accesses are reported as errors without touching the bus, and the unit holds a stall line to the pipeline while a transaction is in flight.

## Interface
- DW, 64, bus/register data width in bits; legal values 32 and 64. NB = DW/8, OW = log2(NB).
- AW, 64, address width.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- req_valid / req_ready  in / out  1 / 1  request handshake; req_ready = (state==IDLE).
- req_wen  in  1  1 = store, 0 = load.
- req_addr  in  AW  byte address.
- req_wdata  in  DW  store data, right-aligned.
- req_size  in  2  log2 of access bytes (0=B, 1=H, 2=W, 3=D).
- req_sext  in  1  load sign-extend enable.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DW  extended load result (0 for stores and errors).
- resp_err  out  1  valid with resp_valid: misaligned, oversize or bus error.
- me_wait_for_axi  out  1  pipeline stall = (state != IDLE).
- w_valid_i / w_ready_o  out / in  1 / 1  write address+data handshake.
- w_addr_i, w_data_i, w_mask_i  out  AW, DW, NB  write beat.
- w_valid_o / w_ready_i / w_err_o  in / out / in  1 / 1 / 1  write response handshake and error.
- rx_r_valid_i / rx_r_ready_o  out / in  1 / 1  read address handshake.
- rx_r_addr_i, rx_r_size_i  out  AW, 3  read address, size (= req_size).
- rx_data_valid / rx_data_ready  in / out  1 / 1  read data handshake.
- rx_data_read_o, rx_err_o  in  DW, 1  read beat and error.

## Operation
- States: IDLE, AR, R, AW, B, RESP.
- IDLE: on req_valid, latch addr, size, sext, wen, off = addr[OW-1:0]. If off is not a multiple of 2^size, or size > OW → RESP with err=1 and no bus activity. Otherwise → AW (store) or AR (load).
- Bus address = req_addr with low OW bits cleared.
- Store: w_mask_i = ((1<<2^size)-1) << off; w_data_i = req_wdata << (8*off). All offsets 0..NB-1 are supported.
- AW: w_valid_i=1 held, with stable payload, until w_ready_o; then → B with w_ready_i=1. B: on w_valid_o → RESP, err=w_err_o.
- AR: rx_r_valid_i=1 held until rx_r_ready_o; then → R with rx_data_ready=1. R: on rx_data_valid, compute s = rx_data_read_o >> (8*off), truncate to 2^size bytes, sign-extend if sext else zero-extend; size = OW passes through → RESP, err=rx_err_o. On bus error, rdata=0.
- RESP: resp_valid=1 for exactly one cycle → IDLE.
- Valid outputs are never dropped before their ready is seen. Ready/valid seen in the same cycle completes that handshake.

## Timing
- Reset (rst_n=0 at edge): state=IDLE; all valid/ready outputs, resp_*, me_wait_for_axi, w_*_i, rx_r_*_i = 0. Reset mid-transaction abandons it; no resp_valid is produced.
- Request accepted at edge T → me_wait_for_axi=1 from T+1 to the RESP cycle inclusive, 0 the following cycle.
- Minimum load with zero-wait bus: AR at T+1, R at T+2, resp_valid at T+3. Same for stores: AW/B/RESP.
- Error path: resp_valid at T+1, resp_err=1, no bus valid asserted.
- resp_rdata and resp_err are registered and held until the next RESP.
- New request accepted at the earliest in the cycle after RESP (req_ready=1).

## Test plan
- DW=64, SB 0xAB to addr 0x1003 → w_addr_i=0x1000, w_mask_i=0x08, w_data_i[31:24]=0xAB; resp_valid with err=0 after w_valid_o.
- LH sext addr 0x2006, bus returns 0x8001_0000_0000_0000 → resp_rdata=0xFFFF_FFFF_FFFF_8001; LHU → 0x8001.
- LW addr 0x3002 (misaligned) → no rx_r_valid_i, resp_valid at T+1, resp_err=1, rdata=0.
- DW=32, LD size 3 → oversize error; LW zero-wait → resp_valid at exactly T+3.
- Store with w_ready_o delayed 5 cycles → w_valid_i and payload stable for 5 cycles; me_wait_for_axi held; rx_err_o/w_err_o=1 → resp_err=1.
- rst_n low during R state → all outputs 0 next cycle, no resp_valid; the next request proceeds normally.
